// File: rtl/sp_sync_memory.sv
`default_nettype none
// ============================================================================
// Module      : sp_sync_memory
// Description : Single-port synchronous scratch memory of DEPTH words by
//               DATA_WIDTH bits. It has separate write and read enables, one
//               shared address, and a registered read port with one clock of
//               latency. When a read and a write hit the same edge, the read
//               returns the old word. A synchronous active-low reset clears
//               every word and the read register.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_sync_memory #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Storage is a plain register array so that reset can clear it.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Reset clears everything. Otherwise the read samples the pre-edge word,
    // which gives read-before-write when both enables are high together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (wr_en) begin
                r_mem[addr] <= wdata;
            end
            if (rd_en) begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sp_sync_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_sync_memory
// Description : Self-checking bench for sp_sync_memory. It applies a table of
//               directed vectors, a hand-written read-during-write chain and
//               randomized traffic checked against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_sync_memory;

    localparam int C_AW    = 2;
    localparam int C_DW    = 8;
    localparam int C_DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [C_AW-1:0] addr = '0;
    logic            wr_en = 1'b0;
    logic            rd_en = 1'b0;
    logic [C_DW-1:0] wdata = '0;
    logic [C_DW-1:0] rdata;

    int total = 0;
    int bad   = 0;

    // Reference model: an array of words plus the last value returned by a read.
    logic [C_DW-1:0] m_mem [C_DEPTH];
    logic [C_DW-1:0] m_rdata;

    typedef struct {
        bit        rst_n;
        bit        wr;
        bit        rd;
        bit [1:0]  a;
        bit [7:0]  wd;
        bit [7:0]  exp;
        string     name;
    } vec_t;

    vec_t vecs[$];

    sp_sync_memory #(
        .ADDR_WIDTH(C_AW),
        .DATA_WIDTH(C_DW),
        .DEPTH     (C_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .wdata(wdata),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [C_DW-1:0] act,
                         input logic [C_DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: rdata=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, then updates the model from the rules:
    // reset clears all; a read returns the old word; a write stores wdata.
    task automatic cycle(input bit rst_n, input bit wr, input bit rd,
                         input bit [1:0] a, input bit [7:0] wd);
        logic [C_DW-1:0] old;
        @(negedge clk);
        reset = rst_n;
        wr_en = wr;
        rd_en = rd;
        addr  = a;
        wdata = wd;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < C_DEPTH; i++) m_mem[i] = '0;
            m_rdata = '0;
        end else begin
            old = m_mem[a];
            if (rd) m_rdata = old;
            if (wr) m_mem[a] = wd;
        end
    endtask

    function automatic void add(input bit rst_n, input bit wr, input bit rd,
                                input bit [1:0] a, input bit [7:0] wd,
                                input bit [7:0] exp, input string name);
        vec_t v;
        v.rst_n = rst_n; v.wr = wr; v.rd = rd; v.a = a; v.wd = wd;
        v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        for (int i = 0; i < C_DEPTH; i++) m_mem[i] = '0;
        m_rdata = '0;

        // Reset held for two edges while a write is requested.
        add(0, 1, 0, 1, 8'hAA, 8'h00, "reset_edge0");
        add(0, 1, 0, 1, 8'hAA, 8'h00, "reset_edge1");
        add(1, 0, 1, 1, 8'h00, 8'h00, "read_after_reset");
        // Fill 0..3, then read back to back.
        add(1, 1, 0, 0, 8'h11, 8'h00, "write0");
        add(1, 1, 0, 1, 8'h22, 8'h00, "write1");
        add(1, 1, 0, 2, 8'h33, 8'h00, "write2");
        add(1, 1, 0, 3, 8'h44, 8'h00, "write3");
        add(1, 0, 1, 0, 8'h00, 8'h11, "read0");
        add(1, 0, 1, 1, 8'h00, 8'h22, "read1");
        add(1, 0, 1, 2, 8'h00, 8'h33, "read2");
        add(1, 0, 1, 3, 8'h00, 8'h44, "read3");
        add(1, 0, 0, 1, 8'h99, 8'h44, "idle_hold");
        // Read-during-write returns the old word.
        add(1, 1, 1, 2, 8'h5C, 8'h33, "rdw_old");
        add(1, 0, 1, 2, 8'h00, 8'h5C, "rdw_new");
        // Hold while addr 3 is rewritten.
        add(1, 0, 1, 3, 8'h00, 8'h44, "hold_read3");
        for (int i = 0; i < 5; i++) add(1, 1, 0, 3, 8'hF0, 8'h44, "hold");
        add(1, 0, 1, 3, 8'h00, 8'hF0, "hold_release");
        // Mid-run reset after a fill.
        add(1, 1, 0, 0, 8'hA1, 8'hF0, "fill0");
        add(1, 1, 0, 1, 8'hB2, 8'hF0, "fill1");
        add(1, 1, 0, 2, 8'hC3, 8'hF0, "fill2");
        add(1, 1, 1, 3, 8'hD4, 8'hF0, "fill3");
        add(0, 1, 1, 2, 8'hEE, 8'h00, "midrun_reset");
        add(1, 0, 1, 0, 8'h00, 8'h00, "cleared0");
        add(1, 0, 1, 1, 8'h00, 8'h00, "cleared1");
        add(1, 0, 1, 2, 8'h00, 8'h00, "cleared2");
        add(1, 0, 1, 3, 8'h00, 8'h00, "cleared3");
        // Overwrite at the top address; addr 0 must be untouched.
        add(1, 1, 0, 0, 8'h77, 8'h00, "write0_77");
        add(1, 1, 0, 3, 8'hFF, 8'h00, "write3_ff");
        add(1, 1, 0, 3, 8'h01, 8'h00, "write3_01");
        add(1, 0, 1, 3, 8'h00, 8'h01, "overwrite3");
        add(1, 0, 1, 0, 8'h00, 8'h77, "boundary0");

        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd);
            check(vecs[i].name, rdata, vecs[i].exp);
        end

        // Chained read-during-write on one address: each read sees the
        // previous cycle's write.
        cycle(1, 1, 1, 1, 8'h10);
        check("chain_a", rdata, 8'h00);
        cycle(1, 1, 1, 1, 8'h20);
        check("chain_b", rdata, 8'h10);
        cycle(1, 0, 1, 1, 8'h00);
        check("chain_c", rdata, 8'h20);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit rst_n;
            rst_n = ($urandom_range(0, 31) != 0);
            cycle(rst_n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom));
            check("random", rdata, m_rdata);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_sync_memory.md
Name: sp_sync_memory

Overview:
- Single-port, synchronous read/write scratch memory of DEPTH words × DATA_WIDTH bits.
- Sits behind a simple register-style interface with separate write and read enables, one address bus, and separate write and read data buses.
- All state is cleared by a synchronous active-low reset.
- Serves as the DUT for the memory interface/assertion environment.

Parameters:
- ADDR_WIDTH, 2, address bus width.
- DATA_WIDTH, 8, word width of wdata/rdata.
- DEPTH, 2**ADDR_WIDTH (4), number of storage words; every addr value maps to a valid word.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous active-low reset; sampled on the clk rising edge.
- addr  input  ADDR_WIDTH  word address for the current read or write.
- wr_en  input  1  write enable; 1 = write wdata to mem[addr] this edge.
- rd_en  input  1  read enable; 1 = load mem[addr] into rdata this edge.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  registered read data.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (ports named clk and reset).
- Reset, reset==0 at a rising edge:
  - All DEPTH words are cleared to 0.
  - rdata is cleared to 0.
  - wr_en and rd_en are ignored that cycle.
  - Reset asserted mid-operation discards any pending access; no partial write.
- Reset value of rdata: 0.
- Write, reset==1 and wr_en==1 at an edge: mem[addr] <= wdata. The write is visible to a read issued on any later edge.
- Read, reset==1 and rd_en==1 at an edge: rdata <= mem[addr] as held before this edge.
  - Latency: 1 clock. Data is valid after the edge that sampled rd_en.
- Hold: when rd_en==0, rdata keeps its last value.
- Idle: with both enables low, the memory contents and rdata are unchanged.
- Simultaneous wr_en==1 and rd_en==1: both operations occur.
  - rdata receives the OLD contents of mem[addr] (read-before-write).
  - mem[addr] takes wdata.
- Address range: no out-of-range condition because DEPTH = 2**ADDR_WIDTH. Addresses 0 and DEPTH-1 behave identically to the others.
- No handshake or back-pressure. Every enabled access completes in its own cycle; back-to-back accesses are permitted every cycle.
- Storage is a register array (no inference of reset-less RAM), since it must clear on reset.
- Inputs are sampled only at rising edges; no combinational path from inputs to rdata.

Test Plan:
- Reset: hold reset=0 for 2 edges with wr_en=1, addr=1, wdata=8'hAA → rdata=0. A subsequent read of addr 1 returns 8'h00.
- Write then read: write 8'h11, 8'h22, 8'h33, 8'h44 to addr 0..3 on consecutive edges, then read 0..3 back-to-back → rdata = 11, 22, 33, 44, each one edge after its rd_en.
- Read-during-write: mem[2]=8'h33; drive wr_en=1, rd_en=1, addr=2, wdata=8'h5C → rdata=8'h33 after that edge. The next read of addr 2 returns 8'h5C.
- Hold: after reading 8'h44 from addr 3, keep rd_en=0 for 5 cycles while writing addr 3 with 8'hF0 → rdata stays 8'h44 until the next read.
- Mid-run reset: fill all addresses with non-zero data, pulse reset=0 for one edge → rdata=0 and all four addresses read back 0.
- Overwrite/boundary: write addr 3 with 8'hFF, then with 8'h01, then read → rdata=8'h01. Addr 0 is unaffected by these writes.
